mem_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline.
- Holds the EX/MEM pipeline register, which latches EX-stage results on every rising clock edge.
- Contains a word-organised data memory, addressed by the latched ALU result, that serves lw reads and sw writes.
- Outputs feed the MEM/WB register and the forwarding logic.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/mem_stage_dmem.sv | 38 +++
 rtl/mem_stage.sv | 94 +++++++++
 tb/tb_mem_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants
// Purpose: WB_MEM control bit indices, opcodes and datapath widths used by
// the MEM stage and its data memory.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int OPCODE_W = 6;
  localparam int CTRL_W   = 5;

  // Bit positions inside the 5-bit WB_MEM control bundle
  localparam int MEMWRITE = 0;
  localparam int MEMREAD  = 1;
  localparam int REGWRITE = 2;
  localparam int MEMTOREG = 3;
  localparam int LINK     = 4;

  localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;

endpackage

// File: rtl/mem_stage_dmem.sv
// rtl/mem_stage_dmem.sv - word-organised data memory
// Purpose: DMEM_WORDS x 32-bit array, async clear, sync write, comb read.
// Ports:
//   clk   - rising-edge clock
//   rst   - async active-high clear of every word; blocks writes
//   we    - write enable, commits at rising clk
//   addr  - word index
//   wdata - write data
//   rdata - combinational read of mem[addr]
module mem_stage_dmem
  import mips_pkg::*;
#(
  parameter int DMEM_WORDS = 256,
  parameter int DMEM_AW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [DMEM_AW-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem [DMEM_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: EX/MEM register plus data memory
// Purpose: latches EX results every cycle and serves lw/sw against the
// data memory using the latched ALU result as byte address.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (adds Misaligned output,
// suppresses misaligned writes and zeroes misaligned reads).
// Ports:
//   CLK, RESET          - clock, async active-high reset
//   WB_MEM_EX[10:0]     - controls from EX; [10:6] kept, [5:0] dropped
//   EX_Opcode/ALU_RESULT/RT_DATA/RD/PC_4 - EX-stage values
//   WB_MEM[4:0]         - registered controls (MemWrite, MemRead, ...)
//   MEM_*               - registered EX-stage values
//   Read_data           - data-memory read value (0 unless MemRead)
//   Misaligned          - only with DMEM_ALIGN_CHECK_EN
module mem_stage
  import mips_pkg::*;
#(
  parameter int DMEM_WORDS = 256,
  parameter int DMEM_AW    = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [10:0]         WB_MEM_EX,
  input  logic [OPCODE_W-1:0] EX_Opcode,
  input  logic [DATA_W-1:0]   EX_ALU_RESULT,
  input  logic [DATA_W-1:0]   EX_RT_DATA,
  input  logic [REG_W-1:0]    EX_RD,
  input  logic [DATA_W-1:0]   EX_PC_4,
  output logic [CTRL_W-1:0]   WB_MEM,
  output logic [OPCODE_W-1:0] MEM_Opcode,
  output logic [DATA_W-1:0]   MEM_ALU_RESULT,
  output logic [DATA_W-1:0]   MEM_RT_DATA,
  output logic [REG_W-1:0]    MEM_RD,
  output logic [DATA_W-1:0]   MEM_PC_4,
  output logic [DATA_W-1:0]   Read_data
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic                Misaligned
`endif
);

  // EX-only controls end their life in EX
  logic unused_ex_ctrl;
  assign unused_ex_ctrl = ^WB_MEM_EX[5:0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WB_MEM         <= '0;
      MEM_Opcode     <= '0;
      MEM_ALU_RESULT <= '0;
      MEM_RT_DATA    <= '0;
      MEM_RD         <= '0;
      MEM_PC_4       <= '0;
    end else begin
      WB_MEM         <= WB_MEM_EX[10:6];
      MEM_Opcode     <= EX_Opcode;
      MEM_ALU_RESULT <= EX_ALU_RESULT;
      MEM_RT_DATA    <= EX_RT_DATA;
      MEM_RD         <= EX_RD;
      MEM_PC_4       <= EX_PC_4;
    end
  end

  // Low two bits select a byte and high bits wrap: word access only
  logic [DMEM_AW-1:0] word_idx;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               access_ok;
  logic               dmem_we;

  assign word_idx = MEM_ALU_RESULT[DMEM_AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign access_ok  = (MEM_ALU_RESULT[1:0] == 2'b00);
  assign Misaligned = (WB_MEM[MEMWRITE] | WB_MEM[MEMREAD]) & ~access_ok;
`else
  assign access_ok  = 1'b1;
`endif

  assign dmem_we   = WB_MEM[MEMWRITE] & access_ok;
  // Read shows pre-edge contents even when a write is pending this cycle
  assign Read_data = (WB_MEM[MEMREAD] & access_ok) ? dmem_rdata : '0;

  mem_stage_dmem #(
    .DMEM_WORDS(DMEM_WORDS),
    .DMEM_AW   (DMEM_AW)
  ) u_dmem (
    .clk  (CLK),
    .rst  (RESET),
    .we   (dmem_we),
    .addr (word_idx),
    .wdata(MEM_RT_DATA),
    .rdata(dmem_rdata)
  );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;

  localparam int WORDS = 256;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [10:0] WB_MEM_EX;
  logic [5:0]  EX_Opcode;
  logic [31:0] EX_ALU_RESULT, EX_RT_DATA, EX_PC_4;
  logic [4:0]  EX_RD;
  logic [4:0]  WB_MEM;
  logic [5:0]  MEM_Opcode;
  logic [31:0] MEM_ALU_RESULT, MEM_RT_DATA, MEM_PC_4, Read_data;
  logic [4:0]  MEM_RD;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        Misaligned;
`endif

  mem_stage #(.DMEM_WORDS(WORDS), .DMEM_AW(8)) dut (
    .CLK(CLK), .RESET(RESET), .WB_MEM_EX(WB_MEM_EX), .EX_Opcode(EX_Opcode),
    .EX_ALU_RESULT(EX_ALU_RESULT), .EX_RT_DATA(EX_RT_DATA), .EX_RD(EX_RD),
    .EX_PC_4(EX_PC_4), .WB_MEM(WB_MEM), .MEM_Opcode(MEM_Opcode),
    .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_RT_DATA(MEM_RT_DATA), .MEM_RD(MEM_RD),
    .MEM_PC_4(MEM_PC_4), .Read_data(Read_data)
`ifdef DMEM_ALIGN_CHECK_EN
    , .Misaligned(Misaligned)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    logic [4:0]  wb;
    logic [5:0]  op;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [WORDS];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  // Monitor: compares whatever the DUT shows against the expectation due now
  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      check("missed_expectation", 32'(cyc), 32'(e.due));
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("WB_MEM",         32'(WB_MEM), 32'(e.wb));
      check("MEM_Opcode",     32'(MEM_Opcode), 32'(e.op));
      check("MEM_ALU_RESULT", MEM_ALU_RESULT, e.alu);
      check("MEM_RT_DATA",    MEM_RT_DATA, e.rt);
      check("MEM_RD",         32'(MEM_RD), 32'(e.rd));
      check("MEM_PC_4",       MEM_PC_4, e.pc);
      check("Read_data",      Read_data, e.rdata);
`ifdef DMEM_ALIGN_CHECK_EN
      check("Misaligned",     32'(Misaligned), 32'(e.mis));
`endif
    end
  end

  task automatic drive(input logic [10:0] ctrl, input logic [5:0] op, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] rd, input logic [31:0] pc);
    WB_MEM_EX = ctrl; EX_Opcode = op; EX_ALU_RESULT = alu;
    EX_RT_DATA = rt; EX_RD = rd; EX_PC_4 = pc;
  endtask

  // Reference model: instructions are applied in issue order; each read sees
  // every earlier write, and its own write lands afterwards.
  task automatic issue(input logic [10:0] ctrl, input logic [5:0] op, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] rd, input logic [31:0] pc);
    exp_t e;
    int   idx;
    bit   ok;
    bit   mr, mw;
    drive(ctrl, op, alu, rt, rd, pc);
    idx = int'((alu / 4) % WORDS);
    mw  = ctrl[6];
    mr  = ctrl[7];
`ifdef DMEM_ALIGN_CHECK_EN
    ok = (alu % 4) == 0;
`else
    ok = 1'b1;
`endif
    e.due = cyc + 1; e.wb = ctrl[10:6]; e.op = op; e.alu = alu; e.rt = rt;
    e.rd = rd; e.pc = pc;
    e.rdata = (mr && ok) ? model[idx] : 32'h0;
    e.mis = (mr || mw) && ((alu % 4) != 0);
    if (mw && ok) model[idx] = rt;
    sb.push_back(e);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(input int n);
    exp_t z;
    RESET = 1'b1;
    sb.delete();
    foreach (model[i]) model[i] = 32'h0;
    z.wb = '0; z.op = '0; z.alu = '0; z.rt = '0; z.rd = '0; z.pc = '0;
    z.rdata = '0; z.mis = 1'b0;
    for (int i = 0; i < n; i++) begin
      z.due = cyc;
      sb.push_back(z);
      @(posedge CLK); #1;
    end
    RESET = 1'b0;
  endtask

  localparam logic [10:0] C_LW   = 11'b01110000100;
  localparam logic [10:0] C_SW   = 11'b00001000100;
  localparam logic [10:0] C_ADDI = 11'b00100000100;

  initial begin
    RESET = 1'b1;
    foreach (model[i]) model[i] = 32'h0;
    drive(C_LW, 6'b100011, 32'd4, 32'd30, 5'd3, 32'h100);
    @(posedge CLK); #1;
    do_reset(3);

    issue(C_LW,   6'b100011, 32'd4,  32'd40, 5'd4, 32'h104);
    issue(C_SW,   6'b101011, 32'd8,  32'd50, 5'd0, 32'h108);
    issue(C_LW,   6'b100011, 32'd8,  32'd0,  5'd5, 32'h10C);
    issue(C_ADDI, 6'b001000, 32'd20, 32'd60, 5'd6, 32'h110);
    issue(C_LW,   6'b100011, 32'd20, 32'd0,  5'd7, 32'h114);
    issue(C_SW,   6'b101011, 32'd1030, 32'hDEADBEEF, 5'd0, 32'h118);
    issue(C_LW,   6'b100011, 32'd4,  32'd0,  5'd8, 32'h11C);
    // both MemRead and MemWrite: old data visible, write still commits
    issue(11'b00011000000, 6'b100011, 32'd8, 32'd77, 5'd9, 32'h120);
    issue(C_LW,   6'b100011, 32'd8,  32'd0,  5'd9, 32'h124);

    // reset lands while a sw to 12 sits in MEM
    issue(C_SW,   6'b101011, 32'd12, 32'd99, 5'd0, 32'h128);
    do_reset(1);
    issue(C_LW,   6'b100011, 32'd12, 32'd0,  5'd1, 32'h12C);
    issue(C_LW,   6'b100011, 32'd8,  32'd0,  5'd1, 32'h130);

    for (int n = 0; n < 400; n++) begin
      logic [10:0] ctrl;
      logic [31:0] alu;
      int          k;
      k = $urandom_range(0, 9);
      if (k < 4)       ctrl = C_LW;
      else if (k < 7)  ctrl = C_SW;
      else if (k < 8)  ctrl = C_ADDI;
      else             ctrl = 11'($urandom);
      alu = 32'($urandom_range(0, 15)) * 32'd4;
      if ($urandom_range(0, 4) == 0) alu = alu | ($urandom & 32'hFFFF_FC03);
      if (n == 200) do_reset(2);
      issue(ctrl, 6'($urandom), alu, $urandom, 5'($urandom), $urandom);
    end

    for (int w = 0; w < 5 && sb.size() > 0; w++) @(posedge CLK);
    #1;
    if (sb.size() > 0) check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
